pll_lock_sequencer: RTL

Reset/lock sequencer that sits directly downstream of the PLL wrapper. It drives the PLL's RST input and consumes its LOCKED output. It holds the PLL in reset for a fixed width, waits for lock, and requires lock to stay stable before releasing the system reset to the rest of the design. Any lock loss returns the PLL to reset, re-asserts system reset and counts the retry.

---
 rtl/pll_lock_sequencer.sv | 123 ++++++++++++
 1 files changed

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: drives the PLL reset, waits for a synchronized lock, and releases the
// system reset once lock has held steady. Any lock loss in RUN restarts the PLL.
// Build option: define PLL_SEQ_TIMEOUT_EN to bound the time spent waiting for lock.
module pll_lock_sequencer #(
  parameter int unsigned RST_HOLD_CYCLES     = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
  parameter int unsigned CNT_W               = 17
) (
  input  logic       CLKIN1,
  input  logic       RST,
  input  logic       LOCKED,
  output logic       PLL_RST,
  output logic       SYS_RST,
  output logic       READY,
  output logic       LOCK_LOST,
  output logic [3:0] RETRY_CNT
);

  typedef enum logic [1:0] {StResetPll, StWaitLock, StStable, StRun} state_e;

  localparam logic [CNT_W-1:0] HoldLast   = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] StableLast = CNT_W'(LOCK_STABLE_CYCLES - 1);
`ifdef PLL_SEQ_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
`endif

  // Reject parameter sets the shared counter cannot represent.
  if (RST_HOLD_CYCLES < 1 || LOCK_STABLE_CYCLES < 1 || LOCK_TIMEOUT_CYCLES < 1 || CNT_W < 1 ||
      CNT_W < 32 && (((RST_HOLD_CYCLES - 1) >> CNT_W) != 0 ||
                     ((LOCK_STABLE_CYCLES - 1) >> CNT_W) != 0 ||
                     ((LOCK_TIMEOUT_CYCLES - 1) >> CNT_W) != 0)) begin : gen_bad_params
    $error("pll_lock_sequencer: cycle parameters must be >= 1 and fit in CNT_W bits");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sync_q, lock_s;
  logic             retry, lost;
  logic             pll_rst_d, sys_rst_d, ready_d, lock_lost_d;
  logic [3:0]       retry_cnt_d;

  // Two-flop synchronizer bringing the asynchronous LOCKED into the CLKIN1 domain.
  always_ff @(posedge CLKIN1 or posedge RST) begin
    if (RST) begin
      sync_q <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      sync_q <= LOCKED;
      lock_s <= sync_q;
    end
  end

  // State register, shared cycle counter and registered outputs.
  always_ff @(posedge CLKIN1 or posedge RST) begin
    if (RST) begin
      state_q   <= StResetPll;
      cnt_q     <= '0;
      PLL_RST   <= 1'b1;
      SYS_RST   <= 1'b1;
      READY     <= 1'b0;
      LOCK_LOST <= 1'b0;
      RETRY_CNT <= 4'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      PLL_RST   <= pll_rst_d;
      SYS_RST   <= sys_rst_d;
      READY     <= ready_d;
      LOCK_LOST <= lock_lost_d;
      RETRY_CNT <= retry_cnt_d;
    end
  end

  // Next-state logic; the counter restarts on every state change.
  always_comb begin
    state_d = state_q;
    retry   = 1'b0;
    lost    = 1'b0;
    unique case (state_q)
      StResetPll: begin
        if (cnt_q == HoldLast) state_d = StWaitLock;
      end
      StWaitLock: begin
        if (lock_s) begin
          state_d = StStable;
`ifdef PLL_SEQ_TIMEOUT_EN
        end else if (cnt_q == TimeoutLast) begin
          state_d = StResetPll;
          retry   = 1'b1;
`endif
        end
      end
      StStable: begin
        // A lock drop wins over a completing count: treat it as a glitch, not a lock.
        if (!lock_s) begin
          state_d = StWaitLock;
        end else if (cnt_q == StableLast) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (!lock_s) begin
          state_d = StResetPll;
          retry   = 1'b1;
          lost    = 1'b1;
        end
      end
      default: state_d = StResetPll;
    endcase
    cnt_d = (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);
  end

  // Output decode from the next state so the registered outputs track the state register.
  always_comb begin
    pll_rst_d   = (state_d == StResetPll);
    sys_rst_d   = (state_d != StRun);
    ready_d     = (state_d == StRun);
    lock_lost_d = lost;
    retry_cnt_d = (retry && RETRY_CNT != 4'd15) ? RETRY_CNT + 4'd1 : RETRY_CNT;
  end

endmodule
